// File: rtl/rv_pkg.sv
// Shared register-file geometry and writeback source selection for the writeback path.
package rv_pkg;

    localparam int XLEN     = 32;
    localparam int RA_W     = 5;
    localparam int NUM_REGS = 32;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LD   = 2'd2
    } wb_sel_e;

    // x0 is hardwired to zero, so any result aimed at it is a no-op.
    function automatic logic rd_is_live(input logic [RA_W-1:0] rd);
        return (rd != '0);
    endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Small synchronous FIFO holding load results until the register-file write port is free.
module wb_load_fifo #(
    parameter int DATA_W = 37,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        // Power-of-two depth lets the pointers wrap by plain overflow.
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/writeback_unit.sv
// Drives the register-file write port from the ALU (priority) and a buffered load stream,
// and tracks outstanding loads for the hazard unit.
module writeback_unit #(
    parameter int XLEN     = rv_pkg::XLEN,
    parameter int RA_W     = rv_pkg::RA_W,
    parameter int LQ_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alu_valid,
    input  logic [RA_W-1:0]      alu_rd,
    input  logic [XLEN-1:0]      alu_data,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [RA_W-1:0]      ld_rd,
    input  logic [XLEN-1:0]      ld_data,
    input  logic                 ld_issue,
    input  logic [RA_W-1:0]      ld_issue_rd,
    output logic                 rf_we,
    output logic [RA_W-1:0]      rf_wa,
    output logic [XLEN-1:0]      rf_wd,
    output logic [2**RA_W-1:0]   pending_mask,
    output logic                 lq_full
);

    import rv_pkg::*;

    localparam int LQ_W = RA_W + XLEN;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LQ_W-1:0]   fifo_head;
    logic [RA_W-1:0]   head_rd;
    logic [XLEN-1:0]   head_data;
    wb_sel_e           sel;

    logic              rf_we_q, rf_we_d;
    logic [RA_W-1:0]   rf_wa_q, rf_wa_d;
    logic [XLEN-1:0]   rf_wd_q, rf_wd_d;
    logic [2**RA_W-1:0] pend_q, pend_d;

    wb_load_fifo #(
        .DATA_W (LQ_W),
        .DEPTH  (LQ_DEPTH)
    ) u_lq (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({ld_rd, ld_data}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_rd   = fifo_head[LQ_W-1:XLEN];
    assign head_data = fifo_head[XLEN-1:0];

    // Readiness ignores a same-cycle pop so the handshake never depends on arbitration.
    assign ld_ready = rst_n & ~fifo_full;
    assign lq_full  = fifo_full;

    always_comb begin
        fifo_push = ld_valid & ld_ready & rd_is_live(ld_rd);
        sel       = WB_NONE;
        if (alu_valid && rd_is_live(alu_rd)) begin
            sel = WB_ALU;
        end else if (!fifo_empty) begin
            sel = WB_LD;
        end
        fifo_pop = (sel == WB_LD);
    end

    always_comb begin
        rf_we_d = 1'b0;
        rf_wa_d = rf_wa_q;
        rf_wd_d = rf_wd_q;
        case (sel)
            WB_ALU: begin
                rf_we_d = 1'b1;
                rf_wa_d = alu_rd;
                rf_wd_d = alu_data;
            end
            WB_LD: begin
                rf_we_d = 1'b1;
                rf_wa_d = head_rd;
                rf_wd_d = head_data;
            end
            default: ;
        endcase
    end

    // Clear on pop first so a same-cycle issue to the same register keeps the bit set.
    always_comb begin
        pend_d = pend_q;
        if (fifo_pop) begin
            pend_d[head_rd] = 1'b0;
        end
        if (ld_issue && rd_is_live(ld_issue_rd)) begin
            pend_d[ld_issue_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we_q <= 1'b0;
            rf_wa_q <= '0;
            rf_wd_q <= '0;
            pend_q  <= '0;
        end else begin
            rf_we_q <= rf_we_d;
            rf_wa_q <= rf_wa_d;
            rf_wd_q <= rf_wd_d;
            pend_q  <= pend_d;
        end
    end

    assign rf_we        = rf_we_q;
    assign rf_wa        = rf_wa_q;
    assign rf_wd        = rf_wd_q;
    assign pending_mask = pend_q;

endmodule
